spn_cipher_core: RTL
====================

SPN_CIPHER_CORE -- requirements
Module: spn_cipher_core

Interface
REQ-001 Parameter: LANES, 4, number of 8-bit data lanes (legal 1..16).
REQ-002 Parameter: ROUNDS, 8, rounds per block (legal 1..255).
REQ-003 Port: CLK  in  1  single clock, all state updates on the rising edge.
REQ-004 Port: RST_N  in  1  reset, asynchronous and active-low.
REQ-005 Port: EN  in  1  global enable; 0 freezes all state and blocks both handshakes.
REQ-006 Port: IN_VALID  in  1  input block offered.
REQ-007 Port: IN_READY  out  1  core can accept a block.
REQ-008 Port: MODE  in  1  0 = encrypt, 1 = decrypt; sampled at accept.
REQ-009 Port: KEY  in  8  base key; sampled at accept.
REQ-010 Port: DIN  in  8*LANES  input block; lane i = DIN[8i+7:8i].
REQ-011 Port: OUT_VALID  out  1  result held on DOUT.
REQ-012 Port: OUT_READY  in  1  consumer takes result.
REQ-013 Port: DOUT  out  8*LANES  result block, same lane mapping as DIN.
REQ-014 Port: BUSY  out  1  high in RUN.
REQ-015 Port: ROUND  out  8  index of the round being executed; 0 outside RUN.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and DONE.
REQ-017 IN_READY SHALL equal (state==IDLE) AND EN.
REQ-018 An accept is IN_VALID AND IN_READY at a rising edge; it loads DIN into the state register, captures MODE and KEY, and moves the FSM to RUN.
REQ-019 Round key SHALL be K_r = KEY_captured XOR r[7:0].
REQ-020 S(x) SHALL be rotl1(x) XOR 8'h63; Sinv(y) SHALL be rotr1(y XOR 8'h63).
REQ-021 An encrypt round r SHALL compute s_i = S(x_i XOR K_r), then x'_i = s_((i+1) mod LANES).
REQ-022 A decrypt round r SHALL compute u_i = x_((i-1) mod LANES), then x'_i = Sinv(u_i) XOR K_r.
REQ-023 Encrypt SHALL execute r = 0..ROUNDS-1 ascending; decrypt SHALL execute r = ROUNDS-1..0 descending.
REQ-024 The core SHALL execute one round per enabled RUN cycle.
REQ-025 After the final round the FSM SHALL go to DONE, so OUT_VALID rises exactly ROUNDS enabled cycles after the accept edge.
REQ-026 In DONE, DOUT and OUT_VALID SHALL hold until OUT_VALID AND OUT_READY AND EN at an edge, which returns the FSM to IDLE.
REQ-027 IN_READY is 0 in DONE, so no new accept occurs in the same cycle as an output handshake; the earliest next accept is the following cycle.
REQ-028 DOUT SHALL read 0 whenever OUT_VALID is 0.
REQ-029 Changes to DIN, MODE or KEY after the accept SHALL NOT affect the block in flight.
REQ-030 With EN = 0 in any state: state, round counter and data SHALL hold, and all outputs SHALL keep their values except IN_READY, which is 0.
REQ-031 With ROUNDS = 1, the core SHALL pass RUN in one cycle and the single round uses r = 0 in both modes.
REQ-032 Decrypt(Encrypt(D, KEY), KEY) SHALL equal D for every D, KEY, LANES and ROUNDS.

Reset
REQ-033 RST_N low SHALL immediately force: FSM IDLE, round counter 0, data register 0, and all outputs 0 (IN_READY also 0 while RST_N is low).
REQ-034 Reset in RUN or DONE SHALL abort the block with no output produced.
REQ-035 After RST_N rises, the first accept is possible on the first edge where EN = 1 and IN_VALID = 1.

Verification
REQ-036 LANES=4, ROUNDS=1, MODE=0, KEY=00, DIN=32'h00000000 -> DOUT=32'h63636363, OUT_VALID one cycle after accept.
REQ-037 LANES=4, ROUNDS=1, MODE=0, KEY=00, DIN=32'h00000001 -> DOUT=32'h61636363; then MODE=1 on that DOUT -> DOUT=32'h00000001.
REQ-038 Defaults, KEY=8'h5A, DIN=32'h714A03F1 encrypted, then result decrypted -> 32'h714A03F1; each OUT_VALID rises 8 cycles after its accept; ROUND steps 0..7 (encrypt) and 7..0 (decrypt).
REQ-039 Defaults, OUT_READY held 0 for 20 cycles -> DOUT stable and IN_READY=0 throughout; OUT_READY=1 -> IDLE next cycle.
REQ-040 Defaults, EN=0 for 3 cycles mid-RUN -> ROUND frozen and OUT_VALID delayed by exactly 3 cycles with unchanged DOUT.
REQ-041 RST_N pulsed low during RUN at ROUND=4 -> all outputs 0 at once; next block processed correctly from IDLE.

Source files
------------

// File: rtl/spn_cipher_core.sv
// Iterative substitution-permutation block cipher: one round per enabled cycle
// over LANES byte lanes, with valid/ready handshakes on both sides.
module spn_cipher_core #(
  parameter int LANES  = 4,
  parameter int ROUNDS = 8
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               EN,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic               MODE,
  input  logic [7:0]         KEY,
  input  logic [8*LANES-1:0] DIN,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [8*LANES-1:0] DOUT,
  output logic               BUSY,
  output logic [7:0]         ROUND
);

  localparam int         W        = 8 * LANES;
  localparam logic [7:0] LAST_RND = 8'(ROUNDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [7:0]     rnd_q, rnd_d;
  logic [W-1:0]   data_q, data_d;
  logic           mode_q, mode_d;
  logic [7:0]     key_q, key_d;

  logic [7:0]     rkey;
  logic [W-1:0]   enc_sub;
  logic [W-1:0]   enc_next;
  logic [W-1:0]   dec_next;
  logic           accept;
  logic           last_round;

  function automatic logic [7:0] s_box(input logic [7:0] x);
    return {x[6:0], x[7]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] s_inv(input logic [7:0] y);
    logic [7:0] t;
    t = y ^ 8'h63;
    return {t[0], t[7:1]};
  endfunction

  assign rkey = key_q ^ rnd_q;

  // Encrypt substitutes then rotates lanes down by one; decrypt undoes the
  // rotation first and then the substitution, so it is an exact inverse.
  always_comb begin
    enc_sub  = '0;
    enc_next = '0;
    dec_next = '0;
    for (int i = 0; i < LANES; i++) begin
      enc_sub[i*8 +: 8] = s_box(data_q[i*8 +: 8] ^ rkey);
    end
    for (int i = 0; i < LANES; i++) begin
      enc_next[i*8 +: 8] = enc_sub[((i + 1) % LANES)*8 +: 8];
      dec_next[i*8 +: 8] = s_inv(data_q[((i + LANES - 1) % LANES)*8 +: 8]) ^ rkey;
    end
  end

  assign IN_READY   = (state_q == ST_IDLE) && EN && RST_N;
  assign accept     = IN_VALID && IN_READY;
  assign last_round = mode_q ? (rnd_q == 8'd0) : (rnd_q == LAST_RND);

  // NOTE: every signal gets a default before any branch, so no path through
  // this block leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    data_d  = data_q;
    mode_d  = mode_q;
    key_d   = key_q;
    if (EN) begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_d = ST_RUN;
            data_d  = DIN;
            mode_d  = MODE;
            key_d   = KEY;
            rnd_d   = MODE ? LAST_RND : 8'd0;
          end
        end
        ST_RUN: begin
          data_d = mode_q ? dec_next : enc_next;
          if (last_round) begin
            state_d = ST_DONE;
            rnd_d   = 8'd0;
          end else begin
            rnd_d = mode_q ? (rnd_q - 8'd1) : (rnd_q + 8'd1);
          end
        end
        ST_DONE: begin
          if (OUT_READY) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order. The data register is a
  // plain flop vector, so it is reset along with the control state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      rnd_q   <= 8'd0;
      data_q  <= '0;
      mode_q  <= 1'b0;
      key_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      key_q   <= key_d;
    end
  end

  assign OUT_VALID = (state_q == ST_DONE);
  assign BUSY      = (state_q == ST_RUN);
  assign ROUND     = BUSY ? rnd_q : 8'd0;
  assign DOUT      = OUT_VALID ? data_q : '0;

endmodule
